// File: rtl/bootcpy_pkg.sv
// Shared PerInt op codes, copy-engine state encoding and address-width helper for bootcpy.
// Verify states exist only when BOOTCPY_VERIFY_EN is defined.
package bootcpy_pkg;

    localparam logic [1:0] PINOOP = 2'b00;
    localparam logic [1:0] PIWROP = 2'b01;
    localparam logic [1:0] PIRDOP = 2'b10;
    localparam logic [1:0] PIRWOP = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RDREQ,
        ST_RDDAT,
        ST_WRREQ,
        ST_DONE
`ifdef BOOTCPY_VERIFY_EN
        ,
        ST_VRREQ,
        ST_VRDAT,
        ST_VRCMP
`endif
    } state_t;

    // Word-address width: data width minus the byte-offset bits within a word.
    function automatic int addrbits(input int archbitsz);
        return archbitsz - $clog2(archbitsz / 8);
    endfunction

endpackage

// File: rtl/pi_mreq.sv
// PerInt master request register: loads op/addr, holds them until rdy accepts, then drops to PINOOP.
module pi_mreq
    import bootcpy_pkg::*;
#(
    parameter int AW = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_ld,
    input  logic [1:0]    i_op,
    input  logic [AW-1:0] i_addr,
    input  logic          i_rdy,
    output logic [1:0]    o_op,
    output logic [AW-1:0] o_addr,
    output logic          o_acc
);

    logic [1:0]    r_op;
    logic [AW-1:0] r_addr;

    assign o_acc  = (r_op != PINOOP) && i_rdy;
    assign o_op   = r_op;
    assign o_addr = r_addr;

    // Address is left as-is after acceptance; only the op retires.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_op   <= PINOOP;
            r_addr <= '0;
        end else if (i_ld) begin
            r_op   <= i_op;
            r_addr <= i_addr;
        end else if (o_acc) begin
            r_op   <= PINOOP;
        end
    end

endmodule

// File: rtl/bootcpy.sv
// Boot ROM -> RAM shadow copy engine; holds the CPU in reset (cpurst_o) until the copy is done.
// Define BOOTCPY_VERIFY_EN to add a read-back compare pass that flags mismatches on err_o.
module bootcpy
    import bootcpy_pkg::*;
#(
    parameter int          ARCHBITSZ = 16,
    parameter int unsigned SRCADDR   = 0,
    parameter int unsigned DSTADDR   = 0,
    parameter int unsigned COUNT     = 0,
    parameter bit          AUTOSTART = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           start_i,
    output logic [1:0]                     m0_op_o,
    output logic [addrbits(ARCHBITSZ)-1:0] m0_addr_o,
    input  logic [ARCHBITSZ-1:0]           m0_data_i,
    output logic [ARCHBITSZ/8-1:0]         m0_sel_o,
    input  logic                           m0_rdy_i,
    input  logic [addrbits(ARCHBITSZ)-1:0] m0_mapsz_i,
    output logic [1:0]                     m1_op_o,
    output logic [addrbits(ARCHBITSZ)-1:0] m1_addr_o,
    output logic [ARCHBITSZ-1:0]           m1_data_o,
    input  logic [ARCHBITSZ-1:0]           m1_data_i,
    output logic [ARCHBITSZ/8-1:0]         m1_sel_o,
    input  logic                           m1_rdy_i,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o,
    output logic                           cpurst_o
);

    localparam int            AW  = addrbits(ARCHBITSZ);
    localparam logic [AW-1:0] SRC = AW'(SRCADDR);
    localparam logic [AW-1:0] DST = AW'(DSTADDR);
    localparam logic [AW-1:0] CNT = AW'(COUNT);

    state_t               r_state, w_nstate;
    logic [AW-1:0]        r_idx, r_n, w_n, w_idx_inc;
    logic                 r_first;
    logic [ARCHBITSZ-1:0] r_wdata;
    logic                 w_last;
    logic                 w_m0_ld, w_m1_ld, w_m0_acc, w_m1_acc;
    logic [1:0]           w_m1_op;
    logic [AW-1:0]        w_m0_addr, w_m1_addr;

`ifdef BOOTCPY_VERIFY_EN
    logic                 r_err;
    logic                 r_vwait;
    logic [ARCHBITSZ-1:0] r_rom;
`else
    logic                 w_unused;
    assign w_unused = ^m1_data_i;
`endif

    assign w_n       = (CNT != '0) ? CNT : m0_mapsz_i;
    assign w_idx_inc = r_idx + AW'(1);
    assign w_last    = (w_idx_inc == r_n);

    // Requests are loaded on the edge that enters the request state so op/addr are registered.
    always_comb begin
        w_nstate  = r_state;
        w_m0_ld   = 1'b0;
        w_m0_addr = SRC + r_idx;
        w_m1_ld   = 1'b0;
        w_m1_op   = PIWROP;
        w_m1_addr = DST + r_idx;
        case (r_state)
            ST_IDLE: if ((AUTOSTART && r_first) || start_i) w_nstate = ST_LOAD;
            ST_LOAD: begin
                if (w_n == '0) begin
                    w_nstate = ST_DONE;
                end else begin
                    w_nstate  = ST_RDREQ;
                    w_m0_ld   = 1'b1;
                    w_m0_addr = SRC;
                end
            end
            ST_RDREQ: if (w_m0_acc) w_nstate = ST_RDDAT;
            ST_RDDAT: begin
                w_nstate = ST_WRREQ;
                w_m1_ld  = 1'b1;
            end
            ST_WRREQ: begin
                if (w_m1_acc) begin
                    if (!w_last) begin
                        w_nstate  = ST_RDREQ;
                        w_m0_ld   = 1'b1;
                        w_m0_addr = SRC + w_idx_inc;
                    end else begin
`ifdef BOOTCPY_VERIFY_EN
                        w_nstate  = ST_VRREQ;
                        w_m0_ld   = 1'b1;
                        w_m0_addr = SRC;
`else
                        w_nstate  = ST_DONE;
`endif
                    end
                end
            end
            ST_DONE: if (start_i) w_nstate = ST_LOAD;
`ifdef BOOTCPY_VERIFY_EN
            ST_VRREQ: if (w_m0_acc) w_nstate = ST_VRDAT;
            ST_VRDAT: begin
                w_nstate = ST_VRCMP;
                w_m1_ld  = 1'b1;
                w_m1_op  = PIRDOP;
            end
            // r_vwait marks the cycle after the RAM read was accepted, when its data is valid.
            ST_VRCMP: begin
                if (r_vwait) begin
                    if (w_last) begin
                        w_nstate = ST_DONE;
                    end else begin
                        w_nstate  = ST_VRREQ;
                        w_m0_ld   = 1'b1;
                        w_m0_addr = SRC + w_idx_inc;
                    end
                end
            end
`endif
            default: w_nstate = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_first <= 1'b1;
            r_idx   <= '0;
            r_n     <= '0;
            r_wdata <= '0;
`ifdef BOOTCPY_VERIFY_EN
            r_err   <= 1'b0;
            r_vwait <= 1'b0;
            r_rom   <= '0;
`endif
        end else begin
            r_state <= w_nstate;
            r_first <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    r_n   <= w_n;
                    r_idx <= '0;
`ifdef BOOTCPY_VERIFY_EN
                    r_err <= 1'b0;
`endif
                end
                ST_RDDAT: r_wdata <= m0_data_i;
`ifdef BOOTCPY_VERIFY_EN
                ST_WRREQ: if (w_m1_acc) r_idx <= w_last ? '0 : w_idx_inc;
                ST_VRDAT: r_rom <= m0_data_i;
                ST_VRCMP: begin
                    if (r_vwait) begin
                        r_vwait <= 1'b0;
                        r_idx   <= w_idx_inc;
                        if (m1_data_i != r_rom) r_err <= 1'b1;
                    end else if (w_m1_acc) begin
                        r_vwait <= 1'b1;
                    end
                end
`else
                ST_WRREQ: if (w_m1_acc) r_idx <= w_idx_inc;
`endif
                default: ;
            endcase
        end
    end

    pi_mreq #(.AW(AW)) u_m0 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_ld   (w_m0_ld),
        .i_op   (PIRDOP),
        .i_addr (w_m0_addr),
        .i_rdy  (m0_rdy_i),
        .o_op   (m0_op_o),
        .o_addr (m0_addr_o),
        .o_acc  (w_m0_acc)
    );

    pi_mreq #(.AW(AW)) u_m1 (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .i_ld   (w_m1_ld),
        .i_op   (w_m1_op),
        .i_addr (w_m1_addr),
        .i_rdy  (m1_rdy_i),
        .o_op   (m1_op_o),
        .o_addr (m1_addr_o),
        .o_acc  (w_m1_acc)
    );

    assign m0_sel_o  = '1;
    assign m1_sel_o  = '1;
    assign m1_data_o = r_wdata;
    assign busy_o    = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done_o    = (r_state == ST_DONE);
`ifdef BOOTCPY_VERIFY_EN
    assign err_o     = r_err;
    assign cpurst_o  = !((r_state == ST_DONE) && !r_err);
`else
    assign err_o     = 1'b0;
    assign cpurst_o  = (r_state != ST_DONE);
`endif

endmodule
